// File: rtl/wb_regbank_pkg.sv
// Shared types and helpers for the Wishbone register bank and its address decoder.
package wb_regbank_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADR_W  = 30;
   localparam int unsigned SEL_W  = 4;
   localparam int unsigned CNT_W  = 4;

   // IRQ registers are counted back from the top of the bank: idx = NREGS - ofs
   localparam int unsigned IRQ_MASK_OFS = 2;
   localparam int unsigned IRQ_STAT_OFS = 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(n)) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/wb_addr_decode.sv
// Combinational word-address decode: block hit and register index for a slave
// occupying NREGS words at BASE_ADDR.
module wb_addr_decode
   import wb_regbank_pkg::*;
#(
   parameter int unsigned NREGS     = 8,
   parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
   parameter int unsigned IDXW      = clog2(NREGS)
) (
   input  logic [ADR_W-1:0] adr,
   output logic             hit_c,
   output logic [IDXW-1:0]  idx_c
);

   localparam int unsigned      TAGW     = ADR_W - IDXW;
   localparam logic [TAGW-1:0] BASE_TAG = BASE_ADDR[31 -: TAGW];

   always_comb begin
      idx_c = adr[IDXW-1:0];
      hit_c = (adr[ADR_W-1:IDXW] == BASE_TAG) && (32'(idx_c) < NREGS);
   end

endmodule

// File: rtl/wb_regbank.sv
// Wishbone classic slave register bank: NREGS byte-writable registers, wait states,
// error on unmapped words. Define WB_REGBANK_IRQ_EN for the mask/status interrupt pair.
module wb_regbank
   import wb_regbank_pkg::*;
#(
   parameter int unsigned NREGS       = 8,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
   parameter int unsigned WAIT_STATES = 0,
   parameter logic [31:0] RESET_VAL   = 32'h0000_0000
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  stb_i,
   input  logic                  we_i,
   input  logic [ADR_W-1:0]      adr_i,
   input  logic [SEL_W-1:0]      sel_i,
   input  logic [DATA_W-1:0]     dat_i,
   output logic [DATA_W-1:0]     dat_o,
   output logic                  ack_o,
   output logic                  err_o,
   output logic [NREGS*32-1:0]   regs_o
`ifdef WB_REGBANK_IRQ_EN
   ,
   input  logic [DATA_W-1:0]     evt_i,
   output logic                  irq_o
`endif
);

   localparam int unsigned      IDXW     = clog2(NREGS);
   localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                we_q, hit_q;
   logic [IDXW-1:0]     idx_q;
   logic [SEL_W-1:0]    sel_q;
   logic [DATA_W-1:0]   dat_q;
   logic                hit_c;
   logic [IDXW-1:0]     idx_c;
   logic                accept_c, wr_c, ack_d, err_d;
   logic [DATA_W-1:0]   rdat_d, lane_mask_c;
   logic [DATA_W-1:0]   regs_q [NREGS];

   wb_addr_decode #(
      .NREGS     (NREGS),
      .BASE_ADDR (BASE_ADDR),
      .IDXW      (IDXW)
   ) u_dec (
      .adr   (adr_i),
      .hit_c (hit_c),
      .idx_c (idx_c)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (stb_i) state_d = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
         S_WAIT: begin
            if (!stb_i)             state_d = S_IDLE;
            else if (cnt_q == '0)   state_d = S_RESP;
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Response and commit strobes; ack/err/dat_o are registered one cycle after RESP
   always_comb begin
      accept_c = 1'b0;
      wr_c     = 1'b0;
      ack_d    = 1'b0;
      err_d    = 1'b0;
      rdat_d   = '0;
      cnt_d    = cnt_q;
      case (state_q)
         S_IDLE: begin
            accept_c = stb_i;
            cnt_d    = CNT_LOAD;
         end
         S_WAIT: cnt_d = cnt_q - CNT_W'(1);
         S_RESP: begin
            ack_d = hit_q;
            err_d = !hit_q;
            wr_c  = hit_q && we_q;
            if (hit_q && !we_q) rdat_d = regs_q[idx_q];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         we_q  <= 1'b0;
         hit_q <= 1'b0;
         idx_q <= '0;
         sel_q <= '0;
         dat_q <= '0;
         ack_o <= 1'b0;
         err_o <= 1'b0;
         dat_o <= '0;
      end else begin
         cnt_q <= cnt_d;
         ack_o <= ack_d;
         err_o <= err_d;
         dat_o <= rdat_d;
         if (accept_c) begin
            we_q  <= we_i;
            hit_q <= hit_c;
            idx_q <= idx_c;
            sel_q <= sel_i;
            dat_q <= dat_i;
         end
      end
   end

   always_comb begin
      for (int unsigned b = 0; b < SEL_W; b++) lane_mask_c[8*b +: 8] = {8{sel_q[b]}};
   end

`ifdef WB_REGBANK_IRQ_EN
   localparam int unsigned IRQ_MASK_IDX = NREGS - IRQ_MASK_OFS;
   localparam int unsigned IRQ_STAT_IDX = NREGS - IRQ_STAT_OFS;

   logic [DATA_W-1:0] stat_c, clr_c;

   // Status is write-one-to-clear; a new event on the same bit overrides the clear
   always_comb begin
      clr_c = '0;
      if (wr_c && (idx_q == IDXW'(IRQ_STAT_IDX))) clr_c = dat_q & lane_mask_c;
      stat_c = (regs_q[IRQ_STAT_IDX] & ~clr_c) | evt_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) irq_o <= 1'b0;
      else       irq_o <= |(regs_q[IRQ_STAT_IDX] & regs_q[IRQ_MASK_IDX]);
   end
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned k = 0; k < NREGS; k++) regs_q[k] <= RESET_VAL;
      end else begin
         if (wr_c) regs_q[idx_q] <= (regs_q[idx_q] & ~lane_mask_c) | (dat_q & lane_mask_c);
`ifdef WB_REGBANK_IRQ_EN
         regs_q[IRQ_STAT_IDX] <= stat_c;
`endif
      end
   end

   for (genvar k = 0; k < NREGS; k++) begin : g_flat
      assign regs_o[32*k +: 32] = regs_q[k];
   end

endmodule

// File: tb/tb_wb_regbank.sv
// Self-checking bench for wb_regbank: two instances (no wait states / three wait states)
// driven by a vector table, hand-written corner sequences and a randomized model check.
module tb_wb_regbank;

   localparam int unsigned N0  = 8;
   localparam int unsigned N1  = 5;
   localparam logic [31:0] B0  = 32'h0000_1000;
   localparam logic [31:0] B1  = 32'h0000_2000;
   localparam logic [31:0] RV0 = 32'h0000_0000;
   localparam logic [31:0] RV1 = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stb = 1'b0;
   logic        we  = 1'b0;
   logic [29:0] adr = '0;
   logic [3:0]  sel = '0;
   logic [31:0] dat = '0;
   int          cur = 0;

   logic        stb0, stb1, ack0, ack1, err0, err1;
   logic [31:0] dat_o0, dat_o1;
   logic [N0*32-1:0] regs0;
   logic [N1*32-1:0] regs1;
   logic        ack_m, err_m;
   logic [31:0] dat_m;
`ifdef WB_REGBANK_IRQ_EN
   logic [31:0] evt = '0;
   logic        irq0, irq1;
`endif

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] m [2][8];

   typedef struct {
      int          d;
      logic        w;
      logic [31:0] b;
      logic [3:0]  s;
      logic [31:0] v;
      logic [1:0]  resp;
      logic [31:0] rd;
   } vec_t;
   vec_t vt [14];

   always #5 clk = ~clk;

   assign stb0  = stb && (cur == 0);
   assign stb1  = stb && (cur == 1);
   assign ack_m = (cur == 1) ? ack1 : ack0;
   assign err_m = (cur == 1) ? err1 : err0;
   assign dat_m = (cur == 1) ? dat_o1 : dat_o0;

   wb_regbank #(.NREGS(N0), .BASE_ADDR(B0), .WAIT_STATES(0), .RESET_VAL(RV0)) dut0 (
      .clk_i(clk), .rst_i(rst), .stb_i(stb0), .we_i(we), .adr_i(adr), .sel_i(sel),
      .dat_i(dat), .dat_o(dat_o0), .ack_o(ack0), .err_o(err0), .regs_o(regs0)
`ifdef WB_REGBANK_IRQ_EN
      , .evt_i(evt), .irq_o(irq0)
`endif
   );

   wb_regbank #(.NREGS(N1), .BASE_ADDR(B1), .WAIT_STATES(3), .RESET_VAL(RV1)) dut1 (
      .clk_i(clk), .rst_i(rst), .stb_i(stb1), .we_i(we), .adr_i(adr), .sel_i(sel),
      .dat_i(dat), .dat_o(dat_o1), .ack_o(ack1), .err_o(err1), .regs_o(regs1)
`ifdef WB_REGBANK_IRQ_EN
      , .evt_i(evt), .irq_o(irq1)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   function automatic int nregs(input int d);
      return (d == 0) ? N0 : N1;
   endfunction

   function automatic logic [31:0] base(input int d);
      return (d == 0) ? B0 : B1;
   endfunction

   function automatic logic [31:0] get_reg(input int d, input int k);
      if (d == 0) return regs0[32*k +: 32];
      return regs1[32*k +: 32];
   endfunction

   // A word maps when its byte address falls inside [base, base + 4*nregs)
   function automatic logic m_hit(input int d, input logic [31:0] b);
      return (b >= base(d)) && (b < base(d) + 32'(4 * nregs(d)));
   endfunction

   function automatic int m_idx(input int d, input logic [31:0] b);
      return int'((b - base(d)) >> 2);
   endfunction

   function automatic logic [31:0] lanes(input logic [3:0] s);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = {8{s[i]}};
      return r;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 8; k++) begin
         m[0][k] = (k < N0) ? RV0 : 32'h0;
         m[1][k] = (k < N1) ? RV1 : 32'h0;
      end
   endtask

   task automatic model_write(input int d, input logic [31:0] b, input logic [3:0] s,
                              input logic [31:0] v);
      int k;
      logic [31:0] lm;
      k  = m_idx(d, b);
      lm = lanes(s);
`ifdef WB_REGBANK_IRQ_EN
      if (k == nregs(d) - 1) m[d][k] = m[d][k] & ~(v & lm);
      else                   m[d][k] = (m[d][k] & ~lm) | (v & lm);
`else
      m[d][k] = (m[d][k] & ~lm) | (v & lm);
`endif
   endtask

   task automatic check_all(input string tag);
      for (int d = 0; d < 2; d++)
         for (int k = 0; k < nregs(d); k++)
            check($sformatf("%s dut%0d reg%0d", tag, d, k), get_reg(d, k), m[d][k]);
   endtask

   // One bus transfer; returns at the negedge where a response is visible (or after 20 cycles)
   task automatic xfer(input int d, input logic w, input logic [31:0] b, input logic [3:0] s,
                       input logic [31:0] v, output int lat, output logic [1:0] resp,
                       output logic [31:0] rd);
      @(negedge clk);
      cur = d; stb = 1'b1; we = w; adr = b[31:2]; sel = s; dat = v;
      lat = 0;
      while (lat < 20) begin
         @(negedge clk);
         lat++;
         if (ack_m || err_m) break;
      end
      resp = {ack_m, err_m};
      rd   = dat_m;
      stb  = 1'b0;
      we   = 1'b0;
   endtask

   task automatic run(input int d, input logic w, input logic [31:0] b, input logic [3:0] s,
                      input logic [31:0] v, input string tag);
      int lat;
      logic [1:0] resp;
      logic [31:0] rd, exp_rd;
      logic h;
      h      = m_hit(d, b);
      exp_rd = (h && !w) ? m[d][m_idx(d, b)] : 32'h0;
      xfer(d, w, b, s, v, lat, resp, rd);
      check({tag, " resp"}, 32'(resp), h ? 32'd2 : 32'd1);
      check({tag, " latency"}, 32'(lat), (d == 0) ? 32'd2 : 32'd5);
      check({tag, " rdata"}, rd, exp_rd);
      if (h && w) begin
         model_write(d, b, s, v);
         check({tag, " regs_o"}, get_reg(d, m_idx(d, b)), m[d][m_idx(d, b)]);
      end
      @(negedge clk);
      check({tag, " idle"}, {29'b0, ack_m, err_m, |dat_m}, 32'h0);
   endtask

   task automatic watch_quiet(input int d, input int cycles, output logic seen);
      seen = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (d == 0 ? (ack0 || err0) : (ack1 || err1)) seen = 1'b1;
      end
   endtask

   initial begin
      int lat;
      logic [1:0] resp;
      logic [31:0] rd;
      logic seen;

      vt[0]  = '{0, 1'b0, B0 + 32'h04,   4'hF, 32'h0,         2'b10, 32'h0000_0000};
      vt[1]  = '{0, 1'b1, B0 + 32'h08,   4'h5, 32'hDEAD_BEEF, 2'b10, 32'h0000_0000};
      vt[2]  = '{0, 1'b0, B0 + 32'h08,   4'hF, 32'h0,         2'b10, 32'h00AD_00EF};
      vt[3]  = '{0, 1'b1, B0 + 32'h08,   4'h0, 32'hFFFF_FFFF, 2'b10, 32'h0000_0000};
      vt[4]  = '{0, 1'b0, B0 + 32'h08,   4'hF, 32'h0,         2'b10, 32'h00AD_00EF};
      vt[5]  = '{0, 1'b0, B0 + 32'h20,   4'hF, 32'h0,         2'b01, 32'h0000_0000};
      vt[6]  = '{0, 1'b1, B0 + 32'h1000, 4'hF, 32'h1111_1111, 2'b01, 32'h0000_0000};
      vt[7]  = '{1, 1'b0, B1 + 32'h00,   4'hF, 32'h0,         2'b10, 32'hA5A5_0000};
      vt[8]  = '{1, 1'b1, B1 + 32'h08,   4'hF, 32'h0102_0304, 2'b10, 32'h0000_0000};
      vt[9]  = '{1, 1'b0, B1 + 32'h08,   4'h0, 32'h0,         2'b10, 32'h0102_0304};
      vt[10] = '{1, 1'b0, B1 + 32'h14,   4'hF, 32'h0,         2'b01, 32'h0000_0000};
      vt[11] = '{1, 1'b1, B1 + 32'h1000, 4'hF, 32'h2222_2222, 2'b01, 32'h0000_0000};
      vt[12] = '{1, 1'b1, B1 + 32'h04,   4'h8, 32'hAABB_CCDD, 2'b10, 32'h0000_0000};
      vt[13] = '{1, 1'b0, B1 + 32'h04,   4'hF, 32'h0,         2'b10, 32'hAAA5_0000};

      model_reset();
      repeat (3) @(negedge clk);
      check("reset ack/err dut0", {30'b0, ack0, err0}, 32'h0);
      check("reset ack/err dut1", {30'b0, ack1, err1}, 32'h0);
      check("reset dat_o dut0", dat_o0, 32'h0);
      check("reset dat_o dut1", dat_o1, 32'h0);
      check_all("reset");
`ifdef WB_REGBANK_IRQ_EN
      check("reset irq_o", 32'(irq0), 32'h0);
`endif
      rst = 1'b0;

      for (int i = 0; i < 14; i++) begin
         xfer(vt[i].d, vt[i].w, vt[i].b, vt[i].s, vt[i].v, lat, resp, rd);
         check($sformatf("vec%0d resp", i), 32'(resp), 32'(vt[i].resp));
         check($sformatf("vec%0d latency", i), 32'(lat), (vt[i].d == 0) ? 32'd2 : 32'd5);
         check($sformatf("vec%0d rdata", i), rd, vt[i].rd);
         if (vt[i].w && vt[i].resp == 2'b10) begin
            model_write(vt[i].d, vt[i].b, vt[i].s, vt[i].v);
            check($sformatf("vec%0d regs_o", i), get_reg(vt[i].d, m_idx(vt[i].d, vt[i].b)),
                  m[vt[i].d][m_idx(vt[i].d, vt[i].b)]);
         end
         @(negedge clk);
         check($sformatf("vec%0d idle", i), {29'b0, ack_m, err_m, |dat_m}, 32'h0);
      end
      check_all("after vectors");

      // strobe withdrawn during the wait states: no response, no write
      @(negedge clk);
      cur = 1; stb = 1'b1; we = 1'b1; adr = (B1 + 32'h08) >> 2; sel = 4'hF; dat = 32'h1234_5678;
      @(negedge clk);
      @(negedge clk);
      stb = 1'b0; we = 1'b0;
      watch_quiet(1, 8, seen);
      check("abort no response", 32'(seen), 32'h0);
      check("abort reg unchanged", get_reg(1, 2), m[1][2]);

      // reset while a write is waiting: transfer dropped, registers back to reset value
      @(negedge clk);
      cur = 1; stb = 1'b1; we = 1'b1; adr = (B1 + 32'h0C) >> 2; sel = 4'hF; dat = 32'hCAFE_F00D;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1; stb = 1'b0; we = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      watch_quiet(1, 8, seen);
      check("reset-abort no response", 32'(seen), 32'h0);
      check("reset-abort reg", get_reg(1, 3), RV1);
      check_all("after reset abort");

`ifdef WB_REGBANK_IRQ_EN
      run(0, 1'b1, B0 + 32'(4 * (N0 - 2)), 4'hF, 32'h1, "irq mask write");
      @(negedge clk);
      evt = 32'h1;
      @(negedge clk);
      evt = 32'h0;
      m[0][N0-1] = m[0][N0-1] | 32'h1;
      m[1][N1-1] = m[1][N1-1] | 32'h1;
      check("irq status set", get_reg(0, N0 - 1), 32'h1);
      check("irq lags status", 32'(irq0), 32'h0);
      @(negedge clk);
      check("irq raised", 32'(irq0), 32'h1);
      evt = 32'h1;
      xfer(0, 1'b1, B0 + 32'(4 * (N0 - 1)), 4'hF, 32'h1, lat, resp, rd);
      check("w1c+evt resp", 32'(resp), 32'd2);
      check("w1c+evt set wins", get_reg(0, N0 - 1), 32'h1);
      @(negedge clk);
      evt = 32'h0;
      check("w1c+evt irq held", 32'(irq0), 32'h1);
      run(0, 1'b1, B0 + 32'(4 * (N0 - 1)), 4'hF, 32'h1, "w1c alone");
      check("irq cleared", 32'(irq0), 32'h0);
`endif

      for (int i = 0; i < 150; i++) begin
         int d;
         logic [31:0] b;
         d = int'($urandom_range(0, 1));
         if ($urandom_range(0, 9) < 8)
            b = base(d) + 32'(4 * $urandom_range(0, nregs(d) + 1));
         else
            b = base(d) + 32'h0001_0000 + 32'(4 * $urandom_range(0, 7));
         run(d, 1'($urandom_range(0, 1)), b, 4'($urandom), $urandom, $sformatf("rand%0d", i));
      end
      check_all("final");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
